// File: rtl/dmem_hs_pkg.sv
// dmem_hs shared definitions: func3 codes, FSM states.
// Build option DMEM_HS_MISALIGN_TRAP_EN lives in dmem_hs.sv.
package dmem_hs_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  function automatic logic f3_bad(
    input logic       we,
    input logic [2:0] f
  );
    if (we) return f > F3_W;
    return !(f == F3_B || f == F3_H || f == F3_W ||
             f == F3_BU || f == F3_HU);
  endfunction

endpackage

// File: rtl/dmem_load_ext.sv
// Load lane select and sign/zero extension.
module dmem_load_ext
  import dmem_hs_pkg::*;
(
  input  logic [31:0] word,
  input  logic [2:0]  func3,
  input  logic [1:0]  lane,
  output logic [31:0] data
);

  logic [31:0] sh;
  assign sh = word >> {lane, 3'b000};

  always_comb begin
    data = '0;
    unique case (func3)
      F3_B:    data = {{24{sh[7]}}, sh[7:0]};
      F3_H:    data = {{16{sh[15]}}, sh[15:0]};
      F3_W:    data = word;
      F3_BU:   data = {24'd0, sh[7:0]};
      F3_HU:   data = {16'd0, sh[15:0]};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/dmem_hs.sv
// Handshaked RV32I data memory, one outstanding request.
// DMEM_HS_MISALIGN_TRAP_EN: fault misaligned accesses.
module dmem_hs
  import dmem_hs_pkg::*;
#(
  parameter int DEPTH_WORDS = 2048,
  parameter int RD_LAT      = 1,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [2:0]        req_func3,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  logic [31:0] mem [DEPTH_WORDS];

  state_t           state;
  logic [1:0]       cnt;
  logic [IDX_W-1:0] idx;
  logic [1:0]       lane;
  logic             mis, hi, err, acc;
  logic [3:0]       be;
  logic [31:0]      wrep, ld;

  assign idx = req_addr[IDX_W+1:2];
  assign hi  = (req_addr >> (IDX_W + 2)) != '0;
  assign acc = req_valid && req_ready;

`ifdef DMEM_HS_MISALIGN_TRAP_EN
  always_comb begin
    lane = req_addr[1:0];
    mis  = 1'b0;
    unique case (req_func3[1:0])
      2'b01:   mis = req_addr[0];
      2'b10:   mis = |req_addr[1:0];
      default: mis = 1'b0;
    endcase
  end
`else
  // Misaligned halves/words are silently force-aligned.
  always_comb begin
    mis  = 1'b0;
    lane = req_addr[1:0];
    unique case (req_func3[1:0])
      2'b01:   lane = {req_addr[1], 1'b0};
      2'b10:   lane = 2'b00;
      default: lane = req_addr[1:0];
    endcase
  end
`endif

  assign err = f3_bad(req_we, req_func3) || hi || mis;

  always_comb begin
    be   = 4'b0000;
    wrep = req_wdata;
    unique case (req_func3)
      F3_B: begin
        be   = 4'b0001 << lane;
        wrep = {4{req_wdata[7:0]}};
      end
      F3_H: begin
        be   = 4'b0011 << lane;
        wrep = {2{req_wdata[15:0]}};
      end
      F3_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  dmem_load_ext u_ext (
    .word  (mem[idx]),
    .func3 (req_func3),
    .lane  (lane),
    .data  (ld)
  );

  // Memory has no reset; stores commit on the acceptance edge.
  always_ff @(posedge clk) begin
    if (acc && !rst && req_we && !err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wrep[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      req_ready <= 1'b1;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (acc) begin
            rsp_rdata <= (req_we || err) ? '0 : ld;
            rsp_err   <= err;
            req_ready <= 1'b0;
            if (RD_LAT == 1) begin
              state     <= S_RESP;
              rsp_valid <= 1'b1;
            end else begin
              state <= S_WAIT;
              cnt   <= 2'(RD_LAT - 1);
            end
          end
        end
        S_WAIT: begin
          cnt <= cnt - 2'd1;
          if (cnt == 2'd1) begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state     <= S_IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_hs.sv
// Self-checking bench for dmem_hs: vectors, random vs model, corner sequences.
module tb_dmem_hs;

  logic clk = 0;
  always #5 clk = ~clk;

  logic        rst  [3];
  logic        rv   [3];
  logic        rdy  [3];
  logic        we   [3];
  logic [31:0] addr [3];
  logic [31:0] wd   [3];
  logic [2:0]  f3   [3];
  logic        rspv [3];
  logic        rspr [3];
  logic [31:0] rd   [3];
  logic        err  [3];

  dmem_hs u_a (
    .clk(clk), .rst(rst[0]), .req_valid(rv[0]), .req_ready(rdy[0]),
    .req_we(we[0]), .req_addr(addr[0]), .req_wdata(wd[0]),
    .req_func3(f3[0]), .rsp_valid(rspv[0]), .rsp_ready(rspr[0]),
    .rsp_rdata(rd[0]), .rsp_err(err[0]));

  dmem_hs #(.DEPTH_WORDS(16), .RD_LAT(3)) u_b (
    .clk(clk), .rst(rst[1]), .req_valid(rv[1]), .req_ready(rdy[1]),
    .req_we(we[1]), .req_addr(addr[1]), .req_wdata(wd[1]),
    .req_func3(f3[1]), .rsp_valid(rspv[1]), .rsp_ready(rspr[1]),
    .rsp_rdata(rd[1]), .rsp_err(err[1]));

  dmem_hs #(.DEPTH_WORDS(16), .RD_LAT(4)) u_c (
    .clk(clk), .rst(rst[2]), .req_valid(rv[2]), .req_ready(rdy[2]),
    .req_we(we[2]), .req_addr(addr[2]), .req_wdata(wd[2]),
    .req_func3(f3[2]), .rsp_valid(rspv[2]), .rsp_ready(rspr[2]),
    .rsp_rdata(rd[2]), .rsp_err(err[2]));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Byte-addressed reference memory for instance A (2048 words).
  logic [7:0] mm [8192];

  function automatic void model(input logic w, input logic [31:0] a,
                                input logic [31:0] d, input logic [2:0] f,
                                output logic [31:0] r, output logic e);
    int unsigned sz, base;
    logic [31:0] v;
    sz = (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : 4;
    e  = w ? (f > 3'd2) : (f == 3'd3 || f > 3'd5);
    e  = e || (a >= 32'd8192);
`ifdef DMEM_HS_MISALIGN_TRAP_EN
    e  = e || (a % sz != 0);
`endif
    r = 0;
    if (e) return;
    base = a - a % sz;
    if (w) begin
      for (int i = 0; i < int'(sz); i++) mm[base+i] = d[8*i +: 8];
      return;
    end
    v = 0;
    for (int i = 0; i < int'(sz); i++) v = v | (32'(mm[base+i]) << (8*i));
    if (!f[2] && sz < 4 && v[8*sz-1])
      v = v | ~((32'd1 << (8*sz)) - 1);
    r = v;
  endfunction

  task automatic xact(input int k, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [2:0] f,
                      output logic [31:0] r, output logic e,
                      output int lat);
    int n = 0;
    @(negedge clk);
    we[k] = w; addr[k] = a; wd[k] = d; f3[k] = f;
    rv[k] = 1; rspr[k] = 1;
    while (!rdy[k] && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    rv[k] = 0;
    lat = 1;
    while (!rspv[k] && lat < 20) begin @(posedge clk); #1; lat++; end
    r = rd[k]; e = err[k];
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [2:0]  f;
    logic [31:0] er;
    logic        ee;
  } vec_t;

  vec_t vt [12];

  initial begin
    logic [31:0] r, mr, held;
    logic e, me;
    int lat;
    logic [31:0] ta;

    for (int k = 0; k < 3; k++) begin
      rst[k] = 1; rv[k] = 0; rspr[k] = 1; we[k] = 0;
      addr[k] = 0; wd[k] = 0; f3[k] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst%0d_ready", k), 32'(rdy[k]), 1);
      chk($sformatf("rst%0d_valid", k), 32'(rspv[k]), 0);
      chk($sformatf("rst%0d_rdata", k), rd[k], 0);
      chk($sformatf("rst%0d_err", k), 32'(err[k]), 0);
      rst[k] = 0;
    end

    for (int i = 0; i < 16; i++) begin
      ta = $urandom;
      xact(0, 1, 32'(4*i), ta, 3'd2, r, e, lat);
      model(1, 32'(4*i), ta, 3'd2, mr, me);
    end

    vt[0]  = '{1, 32'h10, 32'hDEADBEEF, 3'd2, 32'h0, 0};
    vt[1]  = '{0, 32'h10, 32'h0, 3'd2, 32'hDEADBEEF, 0};
    vt[2]  = '{1, 32'h11, 32'h55, 3'd0, 32'h0, 0};
    vt[3]  = '{0, 32'h10, 32'h0, 3'd2, 32'hDEAD55EF, 0};
    vt[4]  = '{0, 32'h11, 32'h0, 3'd0, 32'h00000055, 0};
    vt[5]  = '{0, 32'h12, 32'h0, 3'd5, 32'h0000DEAD, 0};
    vt[6]  = '{0, 32'h12, 32'h0, 3'd1, 32'hFFFFDEAD, 0};
`ifdef DMEM_HS_MISALIGN_TRAP_EN
    vt[7]  = '{0, 32'h13, 32'h0, 3'd2, 32'h0, 1};
`else
    vt[7]  = '{0, 32'h13, 32'h0, 3'd2, 32'hDEAD55EF, 0};
`endif
    vt[8]  = '{0, 32'h10, 32'h0, 3'd3, 32'h0, 1};
    vt[9]  = '{1, 32'h2000, 32'h12345678, 3'd2, 32'h0, 1};
    vt[10] = '{0, 32'h10, 32'h0, 3'd2, 32'hDEAD55EF, 0};
    vt[11] = '{0, 32'h13, 32'h0, 3'd0, 32'hFFFFFFDE, 0};

    for (int i = 0; i < 12; i++) begin
      xact(0, vt[i].w, vt[i].a, vt[i].d, vt[i].f, r, e, lat);
      model(vt[i].w, vt[i].a, vt[i].d, vt[i].f, mr, me);
      chk($sformatf("vec%0d_rdata", i), r, vt[i].er);
      chk($sformatf("vec%0d_err", i), 32'(e), 32'(vt[i].ee));
      chk($sformatf("vec%0d_lat", i), 32'(lat), 1);
    end

    for (int i = 0; i < 300; i++) begin
      logic w;
      logic [2:0] f;
      w  = 1'($urandom_range(0, 1));
      f  = 3'($urandom_range(0, 7));
      ta = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 15) == 0)
        ta = ta | (32'd1 << $urandom_range(13, 31));
      wd[0] = $urandom;
      model(w, ta, wd[0], f, mr, me);
      xact(0, w, ta, wd[0], f, r, e, lat);
      chk($sformatf("rnd%0d_rdata", i), r, mr);
      chk($sformatf("rnd%0d_err", i), 32'(e), 32'(me));
      chk($sformatf("rnd%0d_lat", i), 32'(lat), 1);
    end

    xact(1, 1, 32'h4, 32'hA5A51234, 3'd2, r, e, lat);
    chk("b_sw_lat", 32'(lat), 3);
    @(negedge clk);
    we[1] = 0; addr[1] = 32'h4; f3[1] = 3'd2; rv[1] = 1; rspr[1] = 0;
    @(posedge clk); #1;
    rv[1] = 0;
    chk("b_cyc1_valid", 32'(rspv[1]), 0);
    @(posedge clk); #1;
    chk("b_cyc2_valid", 32'(rspv[1]), 0);
    @(posedge clk); #1;
    chk("b_cyc3_valid", 32'(rspv[1]), 1);
    chk("b_cyc3_rdata", rd[1], 32'hA5A51234);
    held = rd[1];
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk($sformatf("b_hold%0d_valid", i), 32'(rspv[1]), 1);
      chk($sformatf("b_hold%0d_rdata", i), rd[1], held);
      chk($sformatf("b_hold%0d_ready", i), 32'(rdy[1]), 0);
    end
    rspr[1] = 1;
    @(posedge clk); #1;
    chk("b_after_ready", 32'(rdy[1]), 1);
    chk("b_after_valid", 32'(rspv[1]), 0);

    @(negedge clk);
    we[2] = 1; addr[2] = 32'h8; wd[2] = 32'hCAFEF00D; f3[2] = 3'd2;
    rv[2] = 1;
    @(posedge clk); #1;
    rv[2] = 0; rst[2] = 1;
    @(posedge clk); #1;
    rst[2] = 0;
    chk("c_sw_rst_ready", 32'(rdy[2]), 1);
    chk("c_sw_rst_valid", 32'(rspv[2]), 0);
    @(negedge clk);
    we[2] = 0; f3[2] = 3'd2; rv[2] = 1;
    @(posedge clk); #1;
    rv[2] = 0;
    @(posedge clk); #1;
    rst[2] = 1;
    @(posedge clk); #1;
    rst[2] = 0;
    chk("c_rst_ready", 32'(rdy[2]), 1);
    chk("c_rst_valid", 32'(rspv[2]), 0);
    chk("c_rst_rdata", rd[2], 0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk($sformatf("c_quiet%0d_valid", i), 32'(rspv[2]), 0);
    end
    xact(2, 0, 32'h8, 32'h0, 3'd2, r, e, lat);
    chk("c_lw_rdata", r, 32'hCAFEF00D);
    chk("c_lw_err", 32'(e), 0);
    chk("c_lw_lat", 32'(lat), 4);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
